wfq_finish_tag: RTL and testbench
=================================

Name: wfq_finish_tag

Overview:
Per-flow WFQ finish-tag computation stage, directly downstream of virtual_time; consumes its ovtime as vtime.
On each packet arrival: F = max(vtime, F_last[flow]) + pkt_len/weight.
- Stores F back as that flow's last finish tag.
- Presents F to the scheduler/sorter stage.
- Sequential restoring divider gives fixed, deterministic latency.

Parameters:
NUM_FLOWS, 8, number of flows / depth of last-finish-tag table
FLOW_W, 3, flow_id width, equals clog2(NUM_FLOWS)
DW, 16, width of tags, vtime, pkt_len, weight

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  packet-arrival strobe; sampled only when busy=0
flow_id  in  FLOW_W  flow of arriving packet
pkt_len  in  DW  packet length, unsigned integer
weight  in  DW  flow weight, unsigned Q0.16 fraction (0x8000 = 0.5)
vtime  in  DW  current virtual time from virtual_time.ovtime
busy  out  1  high while a computation is in flight
done  out  1  one-cycle pulse: finish_tag/finish_flow valid
finish_tag  out  DW  computed finish tag
finish_flow  out  FLOW_W  flow_id belonging to finish_tag

Behaviour:
- Reset (synchronous, any state):
  - FSM to IDLE; busy=0, done=0, finish_tag=0, finish_flow=0.
  - All NUM_FLOWS table entries cleared to 0.
  - Reset mid-computation aborts it: no done, no table write.
- FSM: IDLE -> DIV -> ADD -> IDLE.
  - IDLE: start=1 at edge E0 latches flow_id, pkt_len, weight, vtime; loads divider; busy=1 after E0; go DIV.
  - DIV: exactly 16 iterations, edges E1..E16.
    - Restoring fractional divide: remainder starts at pkt_len (17-bit working remainder).
    - Each step: rem<<=1; if rem>=weight then rem-=weight, shift in 1, else shift in 0.
    - Result q = floor(pkt_len*2^16/weight).
  - ADD (edge E17):
    - F = max(vtime_latched, table[flow]) + q, unsigned, saturating at 0xFFFF.
    - Write table[flow]=F; finish_tag=F; finish_flow=flow; done=1; busy=0; state IDLE.
- Latency: done asserted in the cycle after E17, i.e. 17 clocks after start is sampled, regardless of operands.
- Overflow/zero rules, evaluated at start sample, flag latched:
  - weight==0 or pkt_len>=weight: q forced to 0xFFFF.
  - Divider still runs 16 cycles, so latency stays fixed.
- Saturation: if the max operand is 0xFFFF or the sum carries out, F=0xFFFF. No wrap-around.
- start while busy=1: ignored, not queued; latched operands unchanged.
- start in the cycle done=1: accepted (FSM is in IDLE).
  - Same-flow back-to-back reads the table value written at the previous E17.
- done is a single-cycle pulse. finish_tag/finish_flow hold until the next ADD or reset.
- All outputs registered. No combinational path from inputs to outputs.

Optional Feature:
WFQ_FLOW_CLEAR_EN
- Defined: adds ports flow_clr (in, 1) and clr_id (in, FLOW_W).
  - flow_clr=1 zeroes table[clr_id] at that edge, in any FSM state.
  - If it coincides with the ADD write to the same flow, the ADD write wins.
  - Clearing the flow in flight before ADD makes ADD use 0 as F_last.
- Not defined: ports absent; the table is cleared only by rst.

Test Plan:
1. After rst: start flow 0, pkt_len 3, weight 0x8000, vtime 0 -> done exactly 17 clocks later, finish_tag 0x0006, finish_flow 0; busy high for 17 cycles.
2. Back-to-back, start in the done cycle: flow 0, pkt_len 5, weight 0x8000, vtime 0x0002 -> max(2,6)+10 = 0x0010. Then flow 1, pkt_len 4, weight 0x4000, vtime 0x0020 -> 0x0030 (flow 0 table unaffected).
3. Rounding: flow 3, pkt_len 1, weight 0xC000, vtime 0x0005 -> q=1, finish_tag 0x0006. Then flow 3, pkt_len 1, weight 0xFFFF, vtime 0 -> 0x0007.
4. Saturation:
   - Flow 2, pkt_len 8, weight 0x0008 (len>=weight) -> 0xFFFF.
   - Then flow 2, pkt_len 1, weight 0xFFFF -> 0xFFFF (no wrap).
   - Flow 4, weight 0 -> 0xFFFF.
5. Robustness:
   - Pulse start again at cycles 3 and 10 of a busy computation (flow 5, len 2, weight 0x8000, vtime 0) -> single done, finish_tag 0x0004, no second result.
   - Assert rst at cycle 8 of a flow 0 computation -> no done, busy 0. Then flow 0, len 3, weight 0x8000, vtime 0 -> 0x0006 (table cleared).
6. With WFQ_FLOW_CLEAR_EN:
   - After test 1, pulse flow_clr with clr_id 0; then flow 0, len 3, weight 0x8000, vtime 0 -> 0x0006, not 0x000C.
   - Clear coincident with ADD on the same flow -> table keeps the ADD value.

Source files
------------

// File: rtl/wfq_finish_tag.sv
// wfq_finish_tag: per-flow WFQ finish-tag stage.
//   F = max(vtime, F_last[flow]) + floor(pkt_len * 2^16 / weight), saturating.
// The quotient comes from a 16-step restoring divider, so every packet has
// the same latency from start to done.
// Optional build macro WFQ_FLOW_CLEAR_EN adds flow_clr/clr_id, which zero a
// single table entry.
//
// state | meaning
// IDLE  | waiting for start; operands are latched when start is seen
// DIV   | one restoring-divide step per clock, DW steps in total
// ADD   | max + add + saturate, write the table, present the result
module wfq_finish_tag #(
  parameter int NUM_FLOWS = 8,
  parameter int FLOW_W    = 3,
  parameter int DW        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FLOW_W-1:0] flow_id,
  input  logic [DW-1:0]     pkt_len,
  input  logic [DW-1:0]     weight,
  input  logic [DW-1:0]     vtime,
`ifdef WFQ_FLOW_CLEAR_EN
  input  logic              flow_clr,
  input  logic [FLOW_W-1:0] clr_id,
`endif
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     finish_tag,
  output logic [FLOW_W-1:0] finish_flow
);

  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] SAT = '1;

  typedef enum logic [1:0] {IDLE, DIV, ADD} state_t;

  state_t            state_q, state_d;
  logic [FLOW_W-1:0] flow_q, flow_d;
  logic [DW-1:0]     vt_q, vt_d;
  logic [DW-1:0]     w_q, w_d;
  logic [DW:0]       rem_q, rem_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     tag_q, tag_d;
  logic [FLOW_W-1:0] fflow_q, fflow_d;
  logic              tbl_we;
  logic [DW-1:0]     tbl_q [NUM_FLOWS];

  // The working remainder stays below weight while not in overflow, so the
  // shifted value always fits in DW+1 bits.
  logic [DW:0]   rem_sh;
  logic          rem_ge;
  logic [DW-1:0] f_last;
  logic [DW-1:0] base;
  logic [DW-1:0] q_eff;
  logic [DW:0]   sum;
  logic [DW-1:0] f_sat;

  assign rem_sh = {rem_q[DW-1:0], 1'b0};
  assign rem_ge = (rem_sh >= {1'b0, w_q});
  assign f_last = tbl_q[flow_q];
  assign base   = (vt_q > f_last) ? vt_q : f_last;
  assign q_eff  = ovf_q ? SAT : quo_q;
  assign sum    = {1'b0, base} + {1'b0, q_eff};
  assign f_sat  = ((base == SAT) || sum[DW]) ? SAT : sum[DW-1:0];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    flow_d  = flow_q;
    vt_d    = vt_q;
    w_d     = w_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tag_d   = tag_q;
    fflow_d = fflow_q;
    tbl_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          flow_d  = flow_id;
          vt_d    = vtime;
          w_d     = weight;
          rem_d   = {1'b0, pkt_len};
          quo_d   = '0;
          cnt_d   = CW'(DW - 1);
          ovf_d   = (weight == '0) || (pkt_len >= weight);
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (rem_ge) begin
          rem_d = rem_sh - {1'b0, w_q};
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ADD;
      end
      ADD: begin
        tag_d   = f_sat;
        fflow_d = flow_q;
        tbl_we  = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flow_q  <= '0;
      vt_q    <= '0;
      w_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tag_q   <= '0;
      fflow_q <= '0;
    end else begin
      state_q <= state_d;
      flow_q  <= flow_d;
      vt_q    <= vt_d;
      w_q     <= w_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tag_q   <= tag_d;
      fflow_q <= fflow_d;
    end
  end

  // Last-finish-tag table; the ADD write is placed last so it overrides a
  // same-cycle clear of the same flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) tbl_q[i] <= '0;
    end else begin
`ifdef WFQ_FLOW_CLEAR_EN
      if (flow_clr) tbl_q[clr_id] <= '0;
`endif
      if (tbl_we) tbl_q[flow_q] <= f_sat;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign finish_tag  = tag_q;
  assign finish_flow = fflow_q;

endmodule

// File: tb/tb_wfq_finish_tag.sv
// Directed bench for wfq_finish_tag with hand-computed finish tags.
module tb_wfq_finish_tag;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  flow_id;
  logic [15:0] pkt_len;
  logic [15:0] weight;
  logic [15:0] vtime;
`ifdef WFQ_FLOW_CLEAR_EN
  logic        flow_clr;
  logic [2:0]  clr_id;
`endif
  logic        busy;
  logic        done;
  logic [15:0] finish_tag;
  logic [2:0]  finish_flow;

  int passed = 0;
  int total  = 0;

  wfq_finish_tag dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flow_id     (flow_id),
    .pkt_len     (pkt_len),
    .weight      (weight),
    .vtime       (vtime),
`ifdef WFQ_FLOW_CLEAR_EN
    .flow_clr    (flow_clr),
    .clr_id      (clr_id),
`endif
    .busy        (busy),
    .done        (done),
    .finish_tag  (finish_tag),
    .finish_flow (finish_flow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge with the DUT idle; returns after E0.
  task automatic send(input logic [2:0] f, input logic [15:0] l,
                      input logic [15:0] w, input logic [15:0] v);
    start   = 1'b1;
    flow_id = f;
    pkt_len = l;
    weight  = w;
    vtime   = v;
    tick();
    start   = 1'b0;
  endtask

  // Returns in the cycle done is high (or after the cycle budget runs out).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic pkt(input string tag, input logic [2:0] f, input logic [15:0] l,
                     input logic [15:0] w, input logic [15:0] v, input logic [15:0] exp);
    int lat, bcnt;
    send(f, l, w, v);
    wait_done(lat, bcnt);
    check({tag, " latency"}, lat, 17);
    check({tag, " busy cycles"}, bcnt, 17);
    check({tag, " busy low at done"}, {31'b0, busy}, 0);
    check({tag, " finish_tag"}, finish_tag, exp);
    check({tag, " finish_flow"}, finish_flow, f);
  endtask

  int seen;
  int done_cyc;

  initial begin
    rst = 1'b1; start = 1'b0; flow_id = '0; pkt_len = '0; weight = '0; vtime = '0;
`ifdef WFQ_FLOW_CLEAR_EN
    flow_clr = 1'b0; clr_id = '0;
`endif
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset finish_tag", finish_tag, 0);
    check("reset finish_flow", finish_flow, 0);

    // 1: 3/0.5 = 6
    pkt("t1", 3'd0, 16'd3, 16'h8000, 16'h0000, 16'h0006);
    tick();
    check("t1 done one-cycle pulse", {31'b0, done}, 0);
    check("t1 tag holds", finish_tag, 16'h0006);

    // 2: back-to-back, started in the done cycle
    pkt("t2a", 3'd0, 16'd5, 16'h8000, 16'h0002, 16'h0010);
    pkt("t2b", 3'd1, 16'd4, 16'h4000, 16'h0020, 16'h0030);
    tick();

    // 3: truncation of the fractional quotient
    pkt("t3a", 3'd3, 16'd1, 16'hC000, 16'h0005, 16'h0006);
    pkt("t3b", 3'd3, 16'd1, 16'hFFFF, 16'h0000, 16'h0007);
    tick();

    // 4: overflow and saturation
    pkt("t4a", 3'd2, 16'd8, 16'h0008, 16'h0000, 16'hFFFF);
    pkt("t4b", 3'd2, 16'd1, 16'hFFFF, 16'h0000, 16'hFFFF);
    pkt("t4c", 3'd4, 16'd1, 16'h0000, 16'h0000, 16'hFFFF);
    // flow 0 table must still hold 0x10: 0x10 + 3/0.5 = 0x16
    pkt("t4d", 3'd0, 16'd3, 16'h8000, 16'h0000, 16'h0016);
    tick();

    // 5a: start pulses while busy are ignored
    send(3'd5, 16'd2, 16'h8000, 16'h0000);
    seen = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 10) begin
        start = 1'b1; flow_id = 3'd6; pkt_len = 16'd100; weight = 16'h0200; vtime = 16'h1234;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        seen++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
    start = 1'b0;
    check("t5a done count", seen, 1);
    check("t5a done cycle", done_cyc, 17);
    check("t5a finish_tag", finish_tag, 16'h0004);
    check("t5a finish_flow", finish_flow, 3'd5);
    check("t5a busy idle", {31'b0, busy}, 0);

    // 5b: reset mid-computation aborts and clears the table
    send(3'd0, 16'd3, 16'h8000, 16'h0000);
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5b busy after rst", {31'b0, busy}, 0);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) seen++;
      tick();
    end
    check("t5b no done after rst", seen, 0);
    check("t5b tag cleared", finish_tag, 0);
    pkt("t5c", 3'd0, 16'd3, 16'h8000, 16'h0000, 16'h0006);
    tick();

`ifdef WFQ_FLOW_CLEAR_EN
    // 6a: clear flow 0 (table holds 6), next result must not accumulate
    flow_clr = 1'b1; clr_id = 3'd0;
    tick();
    flow_clr = 1'b0;
    pkt("t6a", 3'd0, 16'd3, 16'h8000, 16'h0000, 16'h0006);
    tick();

    // 6b: clear coincident with the ADD write of the same flow
    send(3'd1, 16'd4, 16'h4000, 16'h0000);
    for (int c = 1; c < 17; c++) tick();
    flow_clr = 1'b1; clr_id = 3'd1;
    tick();
    flow_clr = 1'b0;
    check("t6b done", {31'b0, done}, 1);
    check("t6b finish_tag", finish_tag, 16'h0010);
    tick();
    pkt("t6c", 3'd1, 16'd4, 16'h4000, 16'h0000, 16'h0020);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
